// File: rtl/serial_add_pkg.sv
// Shared types and constants for the slice-serial adder controller.
package serial_add_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice-index width; a single-slice build still needs one bit.
    function automatic int idx_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/threebit_adder_ci.sv
// Combinational 3-bit adder with carry in and carry out.
module threebit_adder_ci (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       cin,
    output logic [2:0] sum,
    output logic       coutbit
);

    assign {coutbit, sum} = {1'b0, a} + {1'b0, b} + {3'b000, cin};

endmodule

// File: rtl/serial_add_ctrl.sv
// Slice-serial W-bit adder: one 3-bit slice per clock through a single adder.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NSLICE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SLICE_W*NSLICE-1:0]   op_a,
    input  logic [SLICE_W*NSLICE-1:0]   op_b,
    output logic                        busy,
    output logic                        done,
    output logic [SLICE_W*NSLICE-1:0]   result,
    output logic                        cout
);

    localparam int W     = SLICE_W * NSLICE;
    localparam int IDX_W = idx_width(NSLICE);
    localparam int OFF_W = $clog2(W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       result_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic [OFF_W-1:0]   base_s;
    logic [2:0]         sum_s;
    logic               carry_s;

    assign base_s = OFF_W'(idx_r) * OFF_W'(SLICE_W);

    threebit_adder_ci u_adder (
        .a       (a_r[base_s +: SLICE_W]),
        .b       (b_r[base_s +: SLICE_W]),
        .cin     (carry_r),
        .sum     (sum_s),
        .coutbit (carry_s)
    );

    // Next-state decode; abort only matters while slices are being processed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next_s = IDLE;
                end else if (idx_r == IDX_LAST) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_next_s == DONE);
        end
    end

    // Operand capture and slice-by-slice accumulation of the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r    <= '0;
            carry_r  <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r      <= op_a;
                        b_r      <= op_b;
                        idx_r    <= '0;
                        carry_r  <= 1'b0;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        idx_r    <= '0;
                        carry_r  <= 1'b0;
                        result_r <= '0;
                        cout_r   <= 1'b0;
                    end else begin
                        result_r[base_s +: SLICE_W] <= sum_s;
                        carry_r <= carry_s;
                        if (idx_r == IDX_LAST) begin
                            idx_r  <= '0;
                            cout_r <= carry_s;
                        end else begin
                            idx_r  <= idx_r + IDX_ONE;
                        end
                    end
                end
                DONE: begin
                    idx_r <= '0;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign cout   = cout_r;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter NSLICE, default 4: number of 3-bit slices per operand; operand width W = 3*NSLICE (12 at default).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of an addition in progress.
REQ-006 op_a  input  W  first operand; captured on an accepted start.
REQ-007 op_b  input  W  second operand; captured on an accepted start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse: result and cout are valid.
REQ-010 result  output  W  sum bits, registered.
REQ-011 cout  output  1  carry out of the most significant slice, registered.

Function
REQ-012 The block SHALL compute op_a + op_b serially, one 3-bit slice per clock, least significant slice first, using a single 3-bit adder with carry-in.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 Transitions SHALL be: IDLE->RUN on start=1; RUN->RUN while the slice index < NSLICE-1; RUN->DONE after the slice index NSLICE-1 is processed; DONE->IDLE unconditionally; RUN->IDLE on abort=1.
REQ-015 Start accept (IDLE, start=1 at edge k) SHALL:
- latch op_a and op_b into internal registers;
- clear the slice index and the carry register;
- clear result and cout to 0.
REQ-016 In RUN, each edge SHALL:
- write slice i of result with adder(a[i], b[i], carry);
- update the carry register with the adder carry-out;
- increment i.
REQ-017 Latency: slices are processed at edges k+1..k+NSLICE; done SHALL be high for exactly the cycle following edge k+NSLICE. Start to done is NSLICE+1 cycles (5 at the default).
REQ-018 cout SHALL be loaded with the final carry at edge k+NSLICE.
REQ-019 busy SHALL be high from edge k through the DONE cycle, and low in IDLE.
REQ-020 result and cout SHALL hold their values from DONE until the next accepted start.
REQ-021 start SHALL be ignored in RUN and DONE; no queueing.
REQ-022 start asserted in the cycle after done (state back in IDLE) SHALL be accepted, giving back-to-back operations with one idle cycle.
REQ-023 op_a and op_b changes after acceptance SHALL NOT affect the operation in progress.
REQ-024 abort in RUN SHALL:
- return to IDLE at the next edge;
- leave done low;
- clear result and cout to 0.
REQ-025 abort in IDLE or DONE SHALL have no effect; if start and abort are both high in IDLE, start SHALL win.
REQ-026 All arithmetic SHALL be unsigned modulo 2^W, with the overflow reported only on cout.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, slice index 0, carry 0, operand registers 0, result 0, cout 0, busy 0 and done 0, independent of clk.
REQ-028 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after deassertion SHALL behave as a fresh operation.

Structure
REQ-029 Package serial_add_pkg SHALL hold:
- SLICE_W = 3;
- the FSM state enum (IDLE, RUN, DONE);
- the slice-index width function or constant.
REQ-030 One sub-module, threebit_adder_ci, SHALL be instantiated once: a purely combinational 3-bit adder with ports a[2:0], b[2:0], cin, sum[2:0], coutbit.
REQ-031 Slice selection SHALL use an indexed part-select on the latched operands; no per-slice adder replication.

Verification (NSLICE=4)
REQ-032 rst pulse, then start with op_a=12'd1, op_b=12'd2 -> done exactly 5 cycles after start, result=12'd3, cout=0, busy high for 5 cycles.
REQ-033 op_a=12'hFFF, op_b=12'h001 -> result=12'h000, cout=1; the carry ripples through all 4 slices.
REQ-034 op_a=12'h5B3, op_b=12'h24D -> result=12'h800, cout=0; start held high through busy is ignored, and start in the cycle after done starts a second add 12'h003+12'h003 -> result=12'h006.
REQ-035 Start 12'h7FF+12'h7FF, abort at the third RUN cycle -> next edge IDLE, busy=0, no done pulse, result=0, cout=0.
REQ-036 Start 12'hABC+12'h123, assert rst asynchronously mid-RUN -> all outputs 0 immediately with no done pulse; a following start 12'h00F+12'h001 -> result=12'h010 after 5 cycles.
